// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and transmitter.
//   - Default frame geometry (data bits, oversampling ratio).
//   - Receiver state type and state encodings.
package uart_pkg;

    localparam int unsigned DefaultDataBits   = 8;
    localparam int unsigned DefaultOversample = 16;

    // Receiver state type; encodings kept as plain constants for legacy tools.
    typedef logic [2:0] uart_state_t;

    localparam uart_state_t StIdle   = 3'd0;
    localparam uart_state_t StStart  = 3'd1;
    localparam uart_state_t StData   = 3'd2;
    localparam uart_state_t StParity = 3'd3;
    localparam uart_state_t StStop   = 3'd4;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous input.
// Resets to all ones so an idle-high serial line never looks like a start bit.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high reset
//   d     - asynchronous input
//   q     - synchronized output
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver with a one-deep holding register.
// Optional parity support is compiled in with the UART_PARITY_EN macro.
// Ports:
//   clock        - system clock
//   reset        - asynchronous, active-high reset
//   tick         - one-clock strobe at OVERSAMPLE x baud
//   rx           - asynchronous serial line, idle high
//   rx_ready     - consumer accepts rx_data while rx_valid is high
//   rx_data      - received byte (LSB first on the line)
//   rx_valid     - rx_data holds an unconsumed byte
//   frame_error  - one-clock pulse when the stop bit samples low
//   overrun      - one-clock pulse when a good frame is dropped because rx_valid is high
//   busy         - receiver is not idle
//   parity_error - (UART_PARITY_EN only) one-clock pulse on a parity mismatch
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DefaultDataBits,
    parameter int unsigned OVERSAMPLE  = DefaultOversample,
    parameter int unsigned SYNC_STAGES = 2
`ifdef UART_PARITY_EN
    ,
    parameter bit          PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun,
`ifdef UART_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0] HalfCnt = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

    logic rx_sync;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_sync)
    );

    uart_state_t          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_error_q, frame_error_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_good;
`ifdef UART_PARITY_EN
    logic                 parity_error_q, parity_error_d;
    logic                 par_bad_q, par_bad_d;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        frame_good    = 1'b0;
`ifdef UART_PARITY_EN
        parity_error_d = 1'b0;
        par_bad_d      = par_bad_q;
`endif

        // Handshake runs every clock, independent of tick.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_sync) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfCnt) begin
                        cnt_d = '0;
                        if (rx_sync) begin
                            state_d = StIdle;  // glitch, not a real start bit
                        end else begin
                            state_d = StData;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                        if (idx_q == LastIdx) begin
                            idx_d = '0;
`ifdef UART_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                StParity: begin
                    if (cnt_q == LastCnt) begin
                        cnt_d          = '0;
                        par_bad_d      = rx_sync != ((^shift_q) ^ PARITY_ODD);
                        parity_error_d = par_bad_d;
                        state_d        = StStop;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                        if (!rx_sync) begin
                            frame_error_d = 1'b1;
`ifdef UART_PARITY_EN
                        end else if (!par_bad_q) begin
`else
                        end else begin
`endif
                            frame_good = 1'b1;
                        end
`ifdef UART_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // A same-cycle accept frees the holding register for the new byte.
        if (frame_good) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_PARITY_EN
            parity_error_q <= 1'b0;
            par_bad_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
`ifdef UART_PARITY_EN
            parity_error_q <= parity_error_d;
            par_bad_q      <= par_bad_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != StIdle);
`ifdef UART_PARITY_EN
    assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: self-checking bench for uart_receiver.
// tick every 4 clocks, OVERSAMPLE=16, so one bit period is 64 clocks.
// Optional parity checks are compiled with UART_PARITY_EN.
module tb_uart_receiver;

    localparam int BitClk = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       rx    = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;
`ifdef UART_PARITY_EN
    logic       parity_error;
`endif

    uart_receiver #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .rx           (rx),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_error  (frame_error),
        .overrun      (overrun),
`ifdef UART_PARITY_EN
        .parity_error (parity_error),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Tick strobe: high for one clock out of every four.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clock);
            #1;
            tick = (ph == 3);
            ph   = (ph + 1) % 4;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and pulse/occupancy counters.
    logic [7:0] exp_q[$];
    int         valid_cycles = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         perr_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) valid_cycles++;
            if (frame_error) ferr_cnt++;
            if (overrun) ovr_cnt++;
`ifdef UART_PARITY_EN
            if (parity_error) perr_cnt++;
`endif
            if (rx_valid && prev_valid) check("data_stable", {24'd0, rx_data}, {24'd0, prev_data});
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_valid = rx_valid && !rx_ready;
            prev_data  = rx_data;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        valid_cycles = 0;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        perr_cnt     = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        rx = 1'b0;
        wait_clk(BitClk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BitClk);
        end
`ifdef UART_PARITY_EN
        rx = par_bit;
        wait_clk(BitClk);
`else
        if (par_bit) begin end
`endif
        rx = stop_bit;
        wait_clk(BitClk);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'h3C, stop_bit: 1'b0, exp_valid: 0, exp_ferr: 1};
        vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h81, stop_bit: 1'b1, exp_valid: 1, exp_ferr: 0};

        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ferr", {31'd0, frame_error}, 32'd0);
        check("reset_ovr", {31'd0, overrun}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);

        // Table-driven frames with rx_ready held high.
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clear_counts();
            if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit, ^vecs[i].data);
            wait_clk(2 * BitClk);
            check("valid_cycles", valid_cycles, vecs[i].exp_valid);
            check("ferr_pulses", ferr_cnt, vecs[i].exp_ferr);
            check("ovr_pulses", ovr_cnt, 0);
            check("perr_pulses", perr_cnt, 0);
            check("sb_empty", exp_q.size(), 0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Start glitch: low for 3 ticks only.
        clear_counts();
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        wait_clk(BitClk);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_valid", valid_cycles, 0);

        // Overrun: two frames with consumer stalled.
        clear_counts();
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        wait_clk(BitClk);
        check("hold_valid", {31'd0, rx_valid}, 32'd1);
        check("hold_data", {24'd0, rx_data}, 32'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clk(BitClk);
        check("ovr_pulse", ovr_cnt, 1);
        check("ovr_data", {24'd0, rx_data}, 32'h11);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        rx_ready = 1'b1;
        wait_clk(4);
        check("ovr_drain", exp_q.size(), 0);
        check("ovr_valid_clr", {31'd0, rx_valid}, 32'd0);

        // Reset mid-frame at data bit 4 of 0xFF, then 0x5A.
        clear_counts();
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                wait_clk(BitClk * 5 + BitClk / 2);
                reset = 1'b1;
                wait_clk(3);
                reset = 1'b0;
            end
        join
        wait_clk(2 * BitClk);
        check("rst_no_valid", valid_cycles, 0);
        check("rst_no_ferr", ferr_cnt, 0);
        check("rst_no_ovr", ovr_cnt, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clk(2 * BitClk);
        check("rst_valid", valid_cycles, 1);
        check("rst_sb_empty", exp_q.size(), 0);

`ifdef UART_PARITY_EN
        // Even parity, 0x07 needs parity bit 1; send 0.
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clk(2 * BitClk);
        check("par_err_pulse", perr_cnt, 1);
        check("par_no_valid", valid_cycles, 0);
        check("par_no_ferr", ferr_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
